// File: rtl/clock_enable_select_if.sv
// clock_enable_select_if
//   Bundles the control/status signals of clock_enable_select.
//   master: the controlling side (drives enable, sources, select, mode,
//           prescale; observes the enable pulse and switch status).
//   slave : the clock_enable_select block itself.
//   Signals:
//     en          global enable
//     clk_in      asynchronous tick sources, one bit per source
//     clk_sel     requested source index
//     edge_mode   00 rising, 01 falling, 10 both, 11 none
//     div_val     prescale value, one pulse per (div_val+1) edges
//     clk_ena     registered single-cycle enable pulse
//     sel_active  source index currently in use
//     switching   high while a source change is draining
interface clock_enable_select_if #(
  parameter int NUM_SRC = 8,
  parameter int SEL_W   = 3,
  parameter int DIV_W   = 4
);
  logic               en;
  logic [NUM_SRC-1:0] clk_in;
  logic [SEL_W-1:0]   clk_sel;
  logic [1:0]         edge_mode;
  logic [DIV_W-1:0]   div_val;
  logic               clk_ena;
  logic [SEL_W-1:0]   sel_active;
  logic               switching;

  modport master (
    output en, clk_in, clk_sel, edge_mode, div_val,
    input  clk_ena, sel_active, switching
  );

  modport slave (
    input  en, clk_in, clk_sel, edge_mode, div_val,
    output clk_ena, sel_active, switching
  );
endinterface

// File: rtl/clock_enable_select.sv
// clock_enable_select
//   Clock-enable generator for the 8-bit timer family. Synchronises NUM_SRC
//   asynchronous tick sources, detects edges per edge_mode, selects one
//   source, divides its edge rate by (div_val+1) and emits single-cycle
//   clk_ena pulses. Source changes pass through a two-cycle drain so that no
//   partial or spurious pulse escapes while the selection moves.
//   Parameters: NUM_SRC (2..16), SEL_W (2^SEL_W >= NUM_SRC), DIV_W.
//   Ports:
//     clk  system clock, rising edge
//     rst  synchronous reset, active-high
//     bus  clock_enable_select_if slave modport (see interface header)
//
//   Switch FSM:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_RUN   | sel_active in use, prescaler counts qualifying edges
//   ST_DRAIN | selection changing; clk_ena forced low, div_cnt cleared,
//            | sel_active reloaded from clk_sel on the second cycle
module clock_enable_select #(
  parameter int NUM_SRC = 8,
  parameter int SEL_W   = 3,
  parameter int DIV_W   = 4
) (
  input logic                  clk,
  input logic                  rst,
  clock_enable_select_if.slave bus
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [NUM_SRC-1:0] s1_q, s1_d;
  logic [NUM_SRC-1:0] s2_q, s2_d;
  logic [NUM_SRC-1:0] s3_q, s3_d;
  logic [NUM_SRC-1:0] edge_r_q, edge_r_d;

  logic [0:0]         state_q, state_d;
  logic [1:0]         drain_cnt_q, drain_cnt_d;
  logic [SEL_W-1:0]   sel_active_q, sel_active_d;
  logic               switching_q, switching_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               clk_ena_q, clk_ena_d;

  logic               sel_edge;

  // Synchroniser, history flop and live-mode edge detect.
  always_comb begin
    s1_d = bus.clk_in;
    s2_d = s1_q;
    s3_d = s2_q;
    case (bus.edge_mode)
      2'b00:   edge_r_d = s2_q & ~s3_q;
      2'b01:   edge_r_d = ~s2_q & s3_q;
      2'b10:   edge_r_d = s2_q ^ s3_q;
      default: edge_r_d = '0;
    endcase
  end

  // An index beyond NUM_SRC matches no bit and reads as a silent source.
  always_comb begin
    sel_edge = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_active_q == SEL_W'(i)) sel_edge = edge_r_q[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    sel_active_d = sel_active_q;
    switching_d  = switching_q;
    div_cnt_d    = div_cnt_q;
    clk_ena_d    = 1'b0;
    if (state_q == ST_RUN) begin
      if (bus.clk_sel != sel_active_q) begin
        // The edge that enters DRAIN also raises switching, so no pulse may
        // be issued on it either.
        state_d     = ST_DRAIN;
        drain_cnt_d = 2'd0;
        switching_d = 1'b1;
      end else if (sel_edge && bus.en) begin
        // >= rather than == lets a lowered div_val take effect at the next
        // edge instead of wrapping through the full counter range.
        if (div_cnt_q >= bus.div_val) begin
          clk_ena_d = 1'b1;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
    end else begin
      div_cnt_d   = '0;
      drain_cnt_d = drain_cnt_q + 2'd1;
      if (drain_cnt_q == 2'd1) begin
        sel_active_d = bus.clk_sel;
        state_d      = ST_RUN;
        switching_d  = 1'b0;
        drain_cnt_d  = 2'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q         <= '0;
      s2_q         <= '0;
      s3_q         <= '0;
      edge_r_q     <= '0;
      state_q      <= ST_RUN;
      drain_cnt_q  <= 2'd0;
      sel_active_q <= '0;
      switching_q  <= 1'b0;
      div_cnt_q    <= '0;
      clk_ena_q    <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      edge_r_q     <= edge_r_d;
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      sel_active_q <= sel_active_d;
      switching_q  <= switching_d;
      div_cnt_q    <= div_cnt_d;
      clk_ena_q    <= clk_ena_d;
    end
  end

  assign bus.clk_ena    = clk_ena_q;
  assign bus.sel_active = sel_active_q;
  assign bus.switching  = switching_q;

endmodule
